// File: rtl/sbox_scheduler_if.sv
// Request/response bundle between the round controller, the key scheduler,
// the shared S-box and the scheduler. The scheduler uses the slave view.
interface sbox_scheduler_if;
   logic         st_start;
   logic [127:0] st_in;
   logic         st_busy;
   logic         st_done;
   logic [127:0] st_out;
   logic         key_start;
   logic [31:0]  key_in;
   logic         key_busy;
   logic         key_done;
   logic [31:0]  key_out;
   logic [31:0]  sbox_in;
   logic [31:0]  sbox_out;

   modport slave (
      input  st_start, st_in, key_start, key_in, sbox_out,
      output st_busy, st_done, st_out, key_busy, key_done, key_out, sbox_in
   );

   modport master (
      output st_start, st_in, key_start, key_in, sbox_out,
      input  st_busy, st_done, st_out, key_busy, key_done, key_out, sbox_in
   );
endinterface

// File: rtl/sbox_scheduler.sv
// Time-shares one external 32-bit S-box between a 4-word SubBytes job and a 1-word SubWord job.
// Latency: state job done 5 cycles after acceptance, key job 2 cycles; starts while busy are dropped.
module sbox_scheduler #(
   parameter bit KEY_PRIORITY = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   sbox_scheduler_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ST_RUN, KEY_RUN} state_t;

   state_t         state_q;
   logic [1:0]     cnt_q;
   logic [127:0]   st_word_q;
   logic [127:0]   st_out_q;
   logic [31:0]    key_word_q;
   logic [31:0]    key_out_q;
   logic [31:0]    sbox_in_q;
   logic           st_busy_q;
   logic           key_busy_q;
   logic           st_done_q;
   logic           key_done_q;
   logic           key_won_q;

   logic           st_accept;
   logic           key_accept;
   logic           contest;
   logic           grant_key;
   logic [1:0]     cnt_d;
   logic [31:0]    next_word_d;

   always_comb begin
      st_accept   = bus.st_start && !st_busy_q;
      key_accept  = bus.key_start && !key_busy_q;
      contest     = st_busy_q && key_busy_q;
      // key_won_q remembers the winner of the last contest only; uncontested grants leave it alone
      grant_key   = key_busy_q && (!st_busy_q || KEY_PRIORITY || !key_won_q);
      cnt_d       = cnt_q + 2'd1;
      next_word_d = st_word_q[{cnt_d, 5'd0} +: 32];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 2'd0;
         st_word_q  <= '0;
         st_out_q   <= '0;
         key_word_q <= '0;
         key_out_q  <= '0;
         sbox_in_q  <= '0;
         st_busy_q  <= 1'b0;
         key_busy_q <= 1'b0;
         st_done_q  <= 1'b0;
         key_done_q <= 1'b0;
         key_won_q  <= 1'b1;
      end else begin
         st_done_q  <= 1'b0;
         key_done_q <= 1'b0;
         if (st_accept) begin
            st_word_q <= bus.st_in;
            st_busy_q <= 1'b1;
         end
         if (key_accept) begin
            key_word_q <= bus.key_in;
            key_busy_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (grant_key) begin
                  if (contest) key_won_q <= 1'b1;
                  state_q   <= KEY_RUN;
                  sbox_in_q <= key_word_q;
               end else if (st_busy_q) begin
                  if (contest) key_won_q <= 1'b0;
                  state_q   <= ST_RUN;
                  cnt_q     <= 2'd0;
                  sbox_in_q <= st_word_q[31:0];
               end
            end
            ST_RUN: begin
               st_out_q[{cnt_q, 5'd0} +: 32] <= bus.sbox_out;
               cnt_q <= cnt_d;
               if (cnt_q == 2'd3) begin
                  st_done_q <= 1'b1;
                  st_busy_q <= 1'b0;
                  state_q   <= IDLE;
                  sbox_in_q <= '0;
               end else begin
                  sbox_in_q <= next_word_d;
               end
            end
            KEY_RUN: begin
               key_out_q  <= bus.sbox_out;
               key_done_q <= 1'b1;
               key_busy_q <= 1'b0;
               state_q    <= IDLE;
               sbox_in_q  <= '0;
            end
            default: begin
               state_q   <= IDLE;
               sbox_in_q <= '0;
            end
         endcase
      end
   end

   assign bus.st_busy  = st_busy_q;
   assign bus.st_done  = st_done_q;
   assign bus.st_out   = st_out_q;
   assign bus.key_busy = key_busy_q;
   assign bus.key_done = key_done_q;
   assign bus.key_out  = key_out_q;
   assign bus.sbox_in  = sbox_in_q;

endmodule

// File: tb/tb_sbox_scheduler.sv
// Directed bench: one round-robin and one key-priority scheduler share stimulus,
// each backed by its own behavioural AES S-box.
module tb_sbox_scheduler;

   localparam logic [2047:0] SBOX_TAB = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [127:0] S1 = 128'hFFFFFFFF_53535353_01010101_00000000;
   localparam logic [127:0] R1 = 128'h16161616_EDEDEDED_7C7C7C7C_63636363;
   localparam logic [127:0] S2 = 128'h00010203_10111213_20212223_30313233;
   localparam logic [127:0] R2 = 128'h637c777b_ca82c97d_b7fd9326_04c723c3;
   localparam logic [127:0] S3 = 128'h50515253_60616263_70717273_80818283;
   localparam logic [127:0] R3 = 128'h53d100ed_d0efaafb_51a3408f_cd0c13ec;
   localparam logic [31:0]  K1 = 32'h5353_0001, Q1 = 32'hEDED_637C;
   localparam logic [31:0]  K2 = 32'h4041_4243, Q2 = 32'h0983_2c1a;
   localparam logic [31:0]  K3 = 32'hf0f1_f2f3, Q3 = 32'h8ca1_890d;

   logic         clk;
   logic         rst;
   logic         st_start;
   logic [127:0] st_in;
   logic         key_start;
   logic [31:0]  key_in;
   int           n_vec;
   int           n_err;

   function automatic logic [31:0] sbox_word(input logic [31:0] w);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
         r[8*i +: 8] = SBOX_TAB[2047 - 8*int'(w[8*i +: 8]) -: 8];
      end
      return r;
   endfunction

   sbox_scheduler_if bus0 ();
   sbox_scheduler_if bus1 ();

   assign bus0.st_start  = st_start;
   assign bus0.st_in     = st_in;
   assign bus0.key_start = key_start;
   assign bus0.key_in    = key_in;
   assign bus0.sbox_out  = sbox_word(bus0.sbox_in);
   assign bus1.st_start  = st_start;
   assign bus1.st_in     = st_in;
   assign bus1.key_start = key_start;
   assign bus1.key_in    = key_in;
   assign bus1.sbox_out  = sbox_word(bus1.sbox_in);

   sbox_scheduler #(.KEY_PRIORITY(1'b0)) u_rr (.clk(clk), .rst(rst), .bus(bus0));
   sbox_scheduler #(.KEY_PRIORITY(1'b1)) u_kp (.clk(clk), .rst(rst), .bus(bus1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      st_start = 1'b0;
      key_start = 1'b0;
      st_in = '0;
      key_in = '0;
      @(negedge clk);
      step(2);
      chk("rst st_busy", bus0.st_busy, 0);
      chk("rst st_done", bus0.st_done, 0);
      chk("rst st_out", bus0.st_out, 0);
      chk("rst key_busy", bus0.key_busy, 0);
      chk("rst key_done", bus0.key_done, 0);
      chk("rst key_out", bus0.key_out, 0);
      chk("rst sbox_in", bus0.sbox_in, 0);
      chk("rst kp st_out", bus1.st_out, 0);
      chk("rst kp sbox_in", bus1.sbox_in, 0);
      rst = 1'b0;
      step(1);

      // single state job
      st_in = S1; st_start = 1'b1; step(1); st_start = 1'b0;
      chk("st busy set", bus0.st_busy, 1);
      for (int i = 1; i <= 5; i++) begin
         step(1);
         chk("single st_done", bus0.st_done, i == 5);
         if (i <= 4) chk("single sbox_in", bus0.sbox_in, S1[32*(i-1) +: 32]);
      end
      chk("single st_out", bus0.st_out, R1);
      chk("single st_busy clr", bus0.st_busy, 0);
      chk("single sbox_in idle", bus0.sbox_in, 0);
      step(1);
      chk("single st_done pulse", bus0.st_done, 0);
      chk("single st_out hold", bus0.st_out, R1);

      // single key job
      key_in = K1; key_start = 1'b1; step(1); key_start = 1'b0;
      chk("key busy set", bus0.key_busy, 1);
      step(1);
      chk("key done early", bus0.key_done, 0);
      chk("key sbox_in", bus0.sbox_in, K1);
      step(1);
      chk("key done", bus0.key_done, 1);
      chk("key out", bus0.key_out, Q1);
      chk("key busy clr", bus0.key_busy, 0);
      chk("key st_out kept", bus0.st_out, R1);

      // reset in the middle of a state job (cnt=2), with starts in the reset cycle
      st_in = S2; st_start = 1'b1; step(1); st_start = 1'b0;
      step(3);
      rst = 1'b1; st_start = 1'b1; key_start = 1'b1;
      step(1);
      rst = 1'b0; st_start = 1'b0; key_start = 1'b0;
      chk("abort st_out", bus0.st_out, 0);
      chk("abort key_out", bus0.key_out, 0);
      chk("abort st_busy", bus0.st_busy, 0);
      chk("abort key_busy", bus0.key_busy, 0);
      chk("abort sbox_in", bus0.sbox_in, 0);
      for (int i = 1; i <= 6; i++) begin
         step(1);
         chk("abort no st_done", bus0.st_done, 0);
         chk("abort no key_done", bus0.key_done, 0);
         chk("abort st idle", bus0.st_busy, 0);
      end

      // first contest after reset: round-robin gives state first
      st_in = S2; key_in = K2; st_start = 1'b1; key_start = 1'b1;
      step(1); st_start = 1'b0; key_start = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         step(1);
         chk("c1 rr st_done", bus0.st_done, i == 5);
         chk("c1 rr key_done", bus0.key_done, i == 7);
         chk("c1 kp key_done", bus1.key_done, i == 2);
         chk("c1 kp st_done", bus1.st_done, i == 7);
      end
      chk("c1 rr st_out", bus0.st_out, R2);
      chk("c1 rr key_out", bus0.key_out, Q2);
      chk("c1 kp st_out", bus1.st_out, R2);
      chk("c1 kp key_out", bus1.key_out, Q2);

      // second contest: round-robin now favours key
      st_in = S3; key_in = K3; st_start = 1'b1; key_start = 1'b1;
      step(1); st_start = 1'b0; key_start = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         step(1);
         chk("c2 rr key_done", bus0.key_done, i == 2);
         chk("c2 rr st_done", bus0.st_done, i == 7);
         chk("c2 kp key_done", bus1.key_done, i == 2);
         chk("c2 kp st_done", bus1.st_done, i == 7);
      end
      chk("c2 rr st_out", bus0.st_out, R3);
      chk("c2 rr key_out", bus0.key_out, Q3);
      chk("c2 kp key_out", bus1.key_out, Q3);

      // third contest: round-robin back to state, key priority stays on key
      st_in = S1; key_in = K1; st_start = 1'b1; key_start = 1'b1;
      step(1); st_start = 1'b0; key_start = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         step(1);
         chk("c3 rr st_done", bus0.st_done, i == 5);
         chk("c3 rr key_done", bus0.key_done, i == 7);
         chk("c3 kp key_done", bus1.key_done, i == 2);
         chk("c3 kp st_done", bus1.st_done, i == 7);
      end
      chk("c3 rr st_out", bus0.st_out, R1);
      chk("c3 kp key_out", bus1.key_out, Q1);

      // restart attempts while busy, including the done edge, are ignored
      st_in = S2; st_start = 1'b1; step(1);
      st_in = S3; st_start = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step(1);
         st_start = (i == 4);
         chk("rs st_done", bus0.st_done, i == 5);
      end
      chk("rs st_out orig", bus0.st_out, R2);
      chk("rs st_busy clr", bus0.st_busy, 0);
      st_start = 1'b1; step(1); st_start = 1'b0;
      chk("rs next accepted", bus0.st_busy, 1);
      for (int i = 1; i <= 5; i++) begin
         step(1);
         chk("rs2 st_done", bus0.st_done, i == 5);
      end
      chk("rs2 st_out", bus0.st_out, R3);
      chk("rs2 key_out kept", bus0.key_out, Q1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sbox_scheduler.md
# sbox_scheduler

Time-shares one 32-bit combinational S-box (`aes_sbox`, four byte lanes) between two requesters. The state path issues 128-bit SubBytes jobs, processed one word per cycle. The key-expansion path issues 32-bit SubWord jobs. The block sits between the round controller / key scheduler and a single external `aes_sbox` instance, so the design carries one S-box instead of two.

## Interface
- `KEY_PRIORITY`, default 0: 0 = round-robin between requesters; 1 = key path always wins a simultaneous contest.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `st_start` input, 1 bit: one-cycle pulse that requests a SubBytes job on `st_in`.
- `st_in` input, 128 bits: state operand, sampled only on an accepted `st_start`.
- `st_busy` output, 1 bit: a state job is pending or in service.
- `st_done` output, 1 bit: one-cycle pulse when `st_out` is complete.
- `st_out` output, 128 bits: SubBytes(`st_in`).
- `key_start` input, 1 bit: one-cycle pulse that requests a SubWord job on `key_in`.
- `key_in` input, 32 bits: key word, sampled only on an accepted `key_start`.
- `key_busy` output, 1 bit: a key job is pending or in service.
- `key_done` output, 1 bit: one-cycle pulse when `key_out` is valid.
- `key_out` output, 32 bits: SubWord(`key_in`).
- `sbox_in` output, 32 bits: drives the shared S-box input.
- `sbox_out` input, 32 bits: shared S-box result, combinational from `sbox_in`.

## Operation
- **Acceptance**
  - `st_start` is accepted at an edge where `st_busy` is 0 before that edge. On acceptance, `st_in` is captured into an internal register and `st_busy` is set.
  - `st_start` is ignored while `st_busy` is 1. This includes the edge at which `st_done` is asserted.
  - `key_start`, `key_in` and `key_busy` behave identically.
- **FSM states:** IDLE, ST_RUN (2-bit word counter `cnt`), KEY_RUN.
- **IDLE**
  - No job pending: stay in IDLE.
  - Only one job pending: grant that job.
  - Both pending, `KEY_PRIORITY`=1: grant key.
  - Both pending, `KEY_PRIORITY`=0: grant the requester not granted last. After reset, the state path wins the first contest.
  - Granting state enters ST_RUN with `cnt`=0. Granting key enters KEY_RUN.
- **ST_RUN**
  - `sbox_in` = captured state word `cnt`, where word k = bits [32k+31:32k]; word 0 goes first.
  - Each edge writes `sbox_out` into `st_out` word `cnt`, then increments `cnt`.
  - At the `cnt`=3 edge: set `st_done`, clear `st_busy`, return to IDLE.
- **KEY_RUN**
  - `sbox_in` = captured key word.
  - At the next edge: `key_out` <= `sbox_out`, set `key_done`, clear `key_busy`, return to IDLE.
- `sbox_in` is 0 in IDLE.
- No preemption: a job in service always runs to completion.
- Output hold: `st_out` and `key_out` keep their last result until overwritten by the next job of the same requester.
  - During a state job, `st_out` is partially updated. It is valid only from `st_done` until the next state grant.
  - `key_out` is never modified by a state job.

## Timing
- Reset (any edge with `rst`=1):
  - FSM goes to IDLE and `cnt` to 0.
  - `st_busy`, `key_busy`, `st_done`, `key_done` go to 0.
  - `st_out` and `key_out` go to 0.
  - The round-robin pointer is set so the state path wins first.
  - `sbox_in` goes to 0.
  - A job in flight is aborted with no done pulse. `start` pulses in the same cycle are dropped.
- An isolated state job accepted at edge n: grant at n+1, words written at n+2..n+5, `st_done`=1 in the cycle after edge n+5.
- An isolated key job accepted at edge n: grant at n+1, `key_done`=1 in the cycle after edge n+2.
- Each completed job returns to IDLE for exactly one cycle before the next grant. No job ever waits on itself.
- Worst-case key latency (`KEY_PRIORITY`=0), with a state job just granted: 5 + 2 = 7 cycles from acceptance to `key_done`.
- Both `start` pulses may arrive in the same cycle. Both are accepted and served sequentially in arbitration order.
- `st_done` and `key_done` are never asserted in the same cycle.

## Test plan
- **Reset values:** assert `rst` for 2 cycles. All outputs are 0 and `sbox_in`=0. Apply `rst` during ST_RUN `cnt`=2: no `st_done`, and `st_out`=0.
- **Single state job:** `st_in`=128'hFFFFFFFF_53535353_01010101_00000000. Result is `st_out`=128'h16161616_EDEDEDED_7C7C7C7C_63636363, with `st_done` exactly 5 cycles after acceptance and `sbox_in` stepping through words 0..3.
- **Single key job:** `key_in`=32'h5353_0001 → `key_out`=32'hEDED_637C, with `key_done` 2 cycles after acceptance. `st_out` is unchanged.
- **Simultaneous starts after reset, `KEY_PRIORITY`=0:**
  - First pair: `st_done` at +5, then `key_done` at +7.
  - Next simultaneous pair: key first (`key_done` at +2), then `st_done` at +7.
- **Simultaneous starts, `KEY_PRIORITY`=1:** key always first, on repeated contests.
- **Restart during busy:** pulse `st_start` with new `st_in` while `st_busy`=1, including the `st_done` edge. The pulse is ignored and the original result is delivered. A pulse on the following cycle is accepted.
